tdc_pulse_gen: RTL

TDC_PULSE_GEN -- requirements
Module: tdc_pulse_gen

---
 rtl/tdc_pulse_gen.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/tdc_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tdc_pulse_gen
//  Purpose  : Timestamp-scheduled pad driver. A FIFO of {time, level} entries
//             is pushed by software. The head entry fires once the free-running
//             coarse time reaches its timestamp. Firing uses a wrap-aware
//             comparison and is gated by the output enable. A fire drives the
//             entry's level onto the registered pad output.
//  Ports    : wb_clk_i      - clock
//             rst_time_n_i  - asynchronous active-low reset
//             time_i        - coarse time (wraps, +0/+1 per cycle)
//             push_i        - append {push_time_i, push_level_i}
//             flush_i       - discard every pending entry
//             en_i          - output enable request (level)
//             clr_flags_i   - clear the late_o / ovf_o sticky flags
//             out_o, oen_o  - registered pad level / active-low enable
//             count_o       - pending entries, full_o = schedule full
//             late_o        - sticky: an entry fired after its timestamp
//             ovf_o         - sticky: a push was dropped because full
//  Revision : 1.0 - initial release
// ============================================================================
module tdc_pulse_gen #(
    parameter int TIME_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     wb_clk_i,
    input  logic                     rst_time_n_i,
    input  logic [TIME_W-1:0]        time_i,
    input  logic                     push_i,
    input  logic [TIME_W-1:0]        push_time_i,
    input  logic                     push_level_i,
    input  logic                     flush_i,
    input  logic                     en_i,
    input  logic                     clr_flags_i,
    output logic                     out_o,
    output logic                     oen_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     late_o,
    output logic                     ovf_o
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    // Entry storage. It carries no reset: count_q == 0 marks every slot
    // invalid, so stale contents are never observed.
    logic [TIME_W-1:0]  time_q  [DEPTH];
    logic               level_q [DEPTH];

    logic [c_PTR_W-1:0] wptr_q,  wptr_d;
    logic [c_PTR_W-1:0] rptr_q,  rptr_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic               out_q,   out_d;
    logic               oen_q;
    logic               late_q,  late_d;
    logic               ovf_q,   ovf_d;

    logic [TIME_W-1:0]  w_diff;
    logic               w_due;
    logic               w_full;
    logic               w_fire;
    logic               w_push_ok;
    logic               w_push_drop;

    // Modular difference: the head is due while time_i is at most half the
    // time range past the timestamp, which makes the compare wrap-safe.
    assign w_diff      = time_i - time_q[rptr_q];
    assign w_due       = ~w_diff[TIME_W-1];
    assign w_full      = (count_q == c_DEPTH);

    // All decisions use pre-edge state, so a fire in the same cycle never
    // frees a slot for a push into a full schedule.
    assign w_fire      = (count_q != '0) & w_due & en_i & ~flush_i;
    assign w_push_ok   = push_i & ~flush_i & ~w_full;
    assign w_push_drop = push_i & ~flush_i &  w_full;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        out_d   = out_q;

        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (w_push_ok) begin
                wptr_d = wptr_q + c_PTR_W'(1);
            end
            if (w_fire) begin
                rptr_d = rptr_q + c_PTR_W'(1);
                out_d  = level_q[rptr_q];
            end
            case ({w_push_ok, w_fire})
                2'b10:   count_d = count_q + c_CNT_W'(1);
                2'b01:   count_d = count_q - c_CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // Set events take priority over the clear request.
        late_d = (w_fire & (w_diff != '0)) | (late_q & ~clr_flags_i);
        ovf_d  = w_push_drop               | (ovf_q  & ~clr_flags_i);
    end

    always_ff @(posedge wb_clk_i or negedge rst_time_n_i) begin
        if (!rst_time_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            out_q   <= 1'b0;
            oen_q   <= 1'b1;
            late_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            out_q   <= out_d;
            oen_q   <= ~en_i;
            late_q  <= late_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_push_ok) begin
            time_q[wptr_q]  <= push_time_i;
            level_q[wptr_q] <= push_level_i;
        end
    end

    assign out_o   = out_q;
    assign oen_o   = oen_q;
    assign count_o = count_q;
    assign full_o  = w_full;
    assign late_o  = late_q;
    assign ovf_o   = ovf_q;

endmodule
`default_nettype wire
